// File: rtl/seq_sub8.sv
// Bit-serial subtractor: one full-subtractor cell, LSB first.
// Result d = x - y - bin with borrow-out and signed overflow.
module seq_sub8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] xs;
    logic [WIDTH-1:0] ys;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             br;

    logic a, b, df, bn;

    assign a  = xs[0];
    assign b  = ys[0];
    assign df = a ^ b ^ br;
    assign bn = (~a & b) | (~(a ^ b) & br);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            xs    <= '0;
            ys    <= '0;
            res   <= '0;
            cnt   <= '0;
            br    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            d     <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        xs    <= x;
                        ys    <= y;
                        br    <= bin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    xs  <= xs >> 1;
                    ys  <= ys >> 1;
                    br  <= bn;
                    res <= {df, res[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    // last cell sees the captured MSBs, so overflow comes from a/b here
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        d     <= {df, res[WIDTH-1:1]};
                        bout  <= bn;
                        ovf   <= (a ^ b) & (df ^ a);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_sub8.sv
// Self-checking bench for seq_sub8: vector table, scoreboard,
// reset-abort and back-to-back sequences.
module tb_seq_sub8;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;

    seq_sub8 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x     (x),
        .y     (y),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         bout;
        logic         ovf;
    } exp_t;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         bin;
        logic [W-1:0] d;
        logic         bout;
        logic         ovf;
        bit           stress;
    } vec_t;

    exp_t         sb[$];
    int           ntests = 0;
    int           nfail  = 0;
    logic [W-1:0] prev_d = '0;

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic exp_t model(input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   input logic c);
        exp_t       r;
        logic [W:0] t;
        t      = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, c};
        r.d    = t[W-1:0];
        r.bout = t[W];
        r.ovf  = (a[W-1] != b[W-1]) && (t[W-1] != a[W-1]);
        return r;
    endfunction

    // Scoreboard: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("d", 32'(d), 32'(e.d));
                chk("bout", 32'(bout), 32'(e.bout));
                chk("ovf", 32'(ovf), 32'(e.ovf));
            end
        end
    end

    // Call at a negedge where the DUT will be IDLE at the next posedge
    task automatic op(input logic [W-1:0] xi, input logic [W-1:0] yi,
                      input logic bi, input exp_t e, input bit stress);
        x     = xi;
        y     = yi;
        bin   = bi;
        start = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = stress;
        x     = W'($urandom);
        y     = W'($urandom);
        bin   = 1'($urandom);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            chk("busy_run", 32'(busy), 32'd1);
            chk("done_run", 32'(done), 32'd0);
            chk("d_hold", 32'(d), 32'(prev_d));
        end
        @(negedge clk);
        chk("done_lat", 32'(done), 32'd1);
        chk("busy_done", 32'(busy), 32'd0);
        start  = 1'b0;
        prev_d = e.d;
    endtask

    vec_t vecs[8];

    initial begin
        exp_t e;
        int   ndone;
        int   first;
        int   second;

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h55, 8'h55, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{8'h3C, 8'h1A, 1'b1, 8'h21, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{8'h01, 8'h80, 1'b0, 8'h81, 1'b1, 1'b1, 1'b0};

        rst   = 1'b1;
        start = 1'b1;
        x     = 8'hAA;
        y     = 8'h11;
        bin   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_d", 32'(d), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);

        // First start lands in the cycle right after reset release
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            e.d    = vecs[i].d;
            e.bout = vecs[i].bout;
            e.ovf  = vecs[i].ovf;
            op(vecs[i].x, vecs[i].y, vecs[i].bin, e, vecs[i].stress);
        end

        // Reset during the 4th RUN cycle aborts the operation
        @(negedge clk);
        x     = 8'h9C;
        y     = 8'h27;
        bin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_d", 32'(d), 32'd0);
        chk("abort_bout", 32'(bout), 32'd0);
        chk("abort_ovf", 32'(ovf), 32'd0);
        rst    = 1'b0;
        prev_d = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("abort_nodone", 32'(done), 32'd0);
        end

        @(negedge clk);
        op(8'h10, 8'h20, 1'b1, model(8'h10, 8'h20, 1'b1), 1'b0);

        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] rx;
            logic [W-1:0] ry;
            logic         rb;
            rx = W'($urandom);
            ry = W'($urandom);
            rb = 1'($urandom);
            @(negedge clk);
            op(rx, ry, rb, model(rx, ry, rb), 1'($urandom));
        end

        // start held high: one result every W+2 cycles
        @(negedge clk);
        x     = 8'hA0;
        y     = 8'h30;
        bin   = 1'b0;
        start = 1'b1;
        sb.push_back(model(8'hA0, 8'h30, 1'b0));
        sb.push_back(model(8'hA0, 8'h30, 1'b0));
        ndone  = 0;
        first  = 0;
        second = 0;
        for (int i = 1; i <= 30 && ndone < 2; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (ndone == 1) first = i;
                else begin
                    second = i;
                    start  = 1'b0;
                end
            end
        end
        start = 1'b0;
        chk("b2b_count", 32'(ndone), 32'd2);
        chk("b2b_first", 32'(first), 32'(W + 1));
        chk("b2b_period", 32'(second - first), 32'(W + 2));

        repeat (W + 4) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/seq_sub8.md
SEQ_SUB8 -- requirements
Module: seq_sub8

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, the reset: synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit, the operation request, sampled only in IDLE.
REQ-005 The block SHALL have port x, input, WIDTH bits, the minuend, sampled when start is accepted.
REQ-006 The block SHALL have port y, input, WIDTH bits, the subtrahend, sampled when start is accepted.
REQ-007 The block SHALL have port bin, input, 1 bit, the borrow-in, sampled when start is accepted.
REQ-008 The block SHALL have port busy, output, 1 bit, high while the block is computing (state RUN).
REQ-009 The block SHALL have port done, output, 1 bit, a single-cycle pulse marking the result as valid.
REQ-010 The block SHALL have port d, output, WIDTH bits, the difference x - y - bin modulo 2^WIDTH.
REQ-011 The block SHALL have port bout, output, 1 bit, the borrow-out, 1 when x < y + bin unsigned.
REQ-012 The block SHALL have port ovf, output, 1 bit, the signed overflow of the two's-complement subtraction.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-014 In IDLE with start=1, the block SHALL, at the next edge, load x and y into internal shift registers, set the borrow flop to bin, clear the bit counter and enter RUN.
REQ-015 In RUN, each cycle SHALL process one bit, LSB first, using one full-subtractor cell:
- diff = a ^ b ^ br
- br_next = (~a & b) | (~(a ^ b) & br)
REQ-016 Each RUN cycle SHALL shift the diff bit into the result register from the MSB side.
REQ-017 After exactly WIDTH RUN cycles, the block SHALL enter DONE, and d, bout and ovf SHALL update at that same edge.
REQ-018 Latency: for start accepted at edge k, busy SHALL be high for cycles k+1 .. k+WIDTH, and done SHALL be high only in cycle k+WIDTH+1.
REQ-019 DONE SHALL last one cycle, then return to IDLE unconditionally; start asserted in DONE SHALL be ignored.
REQ-020 start asserted in RUN SHALL be ignored, and changes on x, y or bin during RUN SHALL not affect the result.
REQ-021 d, bout and ovf SHALL hold their last result from DONE until the next completed operation; they SHALL not change while RUN is in progress.
REQ-022 ovf SHALL equal (x[MSB] != y[MSB]) && (d[MSB] != x[MSB]), using the operands captured at start.
REQ-023 start held high continuously SHALL produce back-to-back operations, one per WIDTH+2 cycles.
REQ-024 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL not wrap within an operation.

Reset
REQ-025 With rst=1 at a rising edge, the FSM SHALL go to IDLE, and busy, done, d, bout and ovf SHALL all be 0, along with the counter and borrow flop.
REQ-026 Reset SHALL take priority over start and over any in-progress operation; an operation aborted mid-RUN SHALL produce no done pulse, and outputs SHALL read 0.
REQ-027 The first start SHALL be accepted in the cycle after rst deasserts.

Verification
REQ-028 The bench SHALL cover x=5, y=3, bin=0 -> done at cycle k+9, d=0x02, bout=0, ovf=0.
REQ-029 The bench SHALL cover x=0x00, y=0x01, bin=0 -> d=0xFF, bout=1, ovf=0.
REQ-030 The bench SHALL cover x=0x55, y=0x55, bin=1 -> d=0xFF, bout=1, ovf=0; and x=0xFF, y=0xFF, bin=0 -> d=0x00, bout=0.
REQ-031 The bench SHALL cover x=0x80, y=0x01, bin=0 -> d=0x7F, bout=0, ovf=1; and x=0x7F, y=0xFF -> d=0x80, ovf=1, bout=1.
REQ-032 The bench SHALL cover a second start pulse with different operands during RUN -> ignored, first result unchanged, exactly one done pulse.
REQ-033 The bench SHALL cover rst=1 at the 4th RUN cycle -> next cycle busy=0, d=0x00, and no done pulse; a new start is then accepted and completes correctly.
